// File: rtl/stk_pkg.sv
// Shared configuration and stack-pipeline types.
// Engine count, pool geometry, opcode/error encodings and LK walker state.
package cfg_pkg;
    localparam int ENGS_N = 4;
endpackage

package stk_pkg;
    localparam int ENGS_N    = cfg_pkg::ENGS_N;
    localparam int ENGID_W   = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int SLOTS_N   = 16;
    localparam int PTR_W     = $clog2(SLOTS_N);
    localparam int DEPTH_MAX = 8;
    localparam int CNT_W     = $clog2(DEPTH_MAX + 1);
    localparam int DAT_W     = 128;

    typedef logic [ENGID_W-1:0] engid_t;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_INV  = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_EMPTY = 2'd1,
        ERR_FULL  = 2'd2
    } err_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } lk_state_t;
endpackage

// File: rtl/stk_pipe_lk_if.sv
// Microcode bus around the LK stage: admission-side request in, EX-side microcode out.
// master = environment (admission + EX), slave = LK stage.
interface stk_pipe_lk_if #(parameter int PTR_W = stk_pkg::PTR_W);
    import stk_pkg::*;

    logic              lk_vld_w;
    engid_t            lk_engid_w;
    opcode_t           lk_opcode_w;
    logic              lk_dat_vld_w;
    logic [DAT_W-1:0]  lk_dat_w;

    logic              ex_vld_r;
    engid_t            ex_engid_r;
    opcode_t           ex_opcode_r;
    logic [PTR_W-1:0]  ex_ptr_r;
    logic              ex_dat_vld_r;
    logic [DAT_W-1:0]  ex_dat_r;
    err_t              ex_err_r;

    modport master (
        output lk_vld_w, lk_engid_w, lk_opcode_w, lk_dat_vld_w, lk_dat_w,
        input  ex_vld_r, ex_engid_r, ex_opcode_r, ex_ptr_r, ex_dat_vld_r, ex_dat_r, ex_err_r
    );

    modport slave (
        input  lk_vld_w, lk_engid_w, lk_opcode_w, lk_dat_vld_w, lk_dat_w,
        output ex_vld_r, ex_engid_r, ex_opcode_r, ex_ptr_r, ex_dat_vld_r, ex_dat_r, ex_err_r
    );
endinterface

// File: rtl/stk_pipe_lk_walk.sv
// INV walker: follows the link chain from a captured head, freeing one slot per cycle.
// Starts the cycle after accept; done flags the cycle that frees the last slot.
module stk_pipe_lk_walk
    import stk_pkg::*;
#(
    parameter int PTR_W = stk_pkg::PTR_W,
    parameter int CNT_W = stk_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  engid_t           start_eng,
    input  logic [PTR_W-1:0] start_ptr,
    input  logic [CNT_W-1:0] start_cnt,
    input  logic [PTR_W-1:0] link_dat,
    output logic             busy,
    output logic [PTR_W-1:0] cursor,
    output engid_t           eng,
    output logic             done
);

    lk_state_t        state;
    logic [CNT_W-1:0] remain;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cursor <= '0;
            remain <= '0;
            eng    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= WALK;
                        busy   <= 1'b1;
                        cursor <= start_ptr;
                        remain <= start_cnt;
                        eng    <= start_eng;
                    end
                end
                WALK: begin
                    cursor <= link_dat;
                    remain <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done = (state == WALK) && (remain == CNT_W'(1));

endmodule

// File: rtl/stk_pipe_lk.sv
// LK stage: resolves PUSH/POP/INV against per-engine head/cnt and the slot link table.
// Latency 1 to EX (INV on k entries: k+1); no backpressure, admission stalls on o_lk_busy.
module stk_pipe_lk
    import stk_pkg::*;
#(
    parameter int ENGS_N    = cfg_pkg::ENGS_N,
    parameter int SLOTS_N   = 16,
    parameter int DEPTH_MAX = 8,
    localparam int PTR_W    = $clog2(SLOTS_N),
    localparam int CNT_W    = $clog2(DEPTH_MAX + 1)
) (
    input  logic             clk,
    input  logic             arst_n,
    stk_pipe_lk_if.slave     lk,
    input  logic [PTR_W-1:0] i_al_ptr,
    output logic             o_al_alloc,
    output logic             o_fr_vld,
    output logic [PTR_W-1:0] o_fr_ptr,
    output logic             o_lk_busy
);

    logic [PTR_W-1:0] head_q [ENGS_N];
    logic [CNT_W-1:0] cnt_q  [ENGS_N];
    logic [PTR_W-1:0] link_q [SLOTS_N];

    engid_t           eng;
    logic [PTR_W-1:0] cur_head;
    logic [CNT_W-1:0] cur_cnt;
    logic             is_push, is_pop, is_inv;
    logic             push_ok, pop_ok, inv_walk;

    logic             walk_busy, walk_done;
    logic [PTR_W-1:0] walk_cursor;
    engid_t           walk_eng;

    assign eng      = lk.lk_engid_w;
    assign cur_head = head_q[eng];
    assign cur_cnt  = cnt_q[eng];

    assign is_push  = lk.lk_vld_w && (lk.lk_opcode_w == OP_PUSH);
    assign is_pop   = lk.lk_vld_w && (lk.lk_opcode_w == OP_POP);
    assign is_inv   = lk.lk_vld_w && (lk.lk_opcode_w == OP_INV);
    assign push_ok  = is_push && (cur_cnt < CNT_W'(DEPTH_MAX));
    assign pop_ok   = is_pop  && (cur_cnt != '0);
    assign inv_walk = is_inv  && (cur_cnt != '0);

    assign o_al_alloc = push_ok;
    // Admission never presents work while busy, so POP and walk frees cannot collide.
    assign o_fr_vld   = pop_ok || walk_busy;
    assign o_fr_ptr   = walk_busy ? walk_cursor : cur_head;
    assign o_lk_busy  = walk_busy;

    stk_pipe_lk_walk #(
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_walk (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (inv_walk),
        .start_eng (eng),
        .start_ptr (cur_head),
        .start_cnt (cur_cnt),
        .link_dat  (link_q[walk_cursor]),
        .busy      (walk_busy),
        .cursor    (walk_cursor),
        .eng       (walk_eng),
        .done      (walk_done)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < ENGS_N; i++) begin
                head_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (push_ok) begin
            head_q[eng] <= i_al_ptr;
            cnt_q[eng]  <= cur_cnt + CNT_W'(1);
        end else if (pop_ok) begin
            head_q[eng] <= link_q[cur_head];
            cnt_q[eng]  <= cur_cnt - CNT_W'(1);
        end else if (inv_walk) begin
            head_q[eng] <= '0;
            cnt_q[eng]  <= '0;
        end
    end

    // Link table holds chain order only; stale entries are harmless once unlinked.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            link_q[i_al_ptr] <= cur_head;
        end
    end

    logic             ex_vld_d;
    engid_t           ex_eng_d;
    opcode_t          ex_op_d;
    logic [PTR_W-1:0] ex_ptr_d;
    logic             ex_dv_d;
    logic [DAT_W-1:0] ex_dat_d;
    err_t             ex_err_d;

    always_comb begin
        ex_vld_d = 1'b0;
        ex_eng_d = '0;
        ex_op_d  = OP_PUSH;
        ex_ptr_d = '0;
        ex_dv_d  = 1'b0;
        ex_dat_d = '0;
        ex_err_d = ERR_OK;
        if (walk_done) begin
            ex_vld_d = 1'b1;
            ex_eng_d = walk_eng;
            ex_op_d  = OP_INV;
            ex_ptr_d = walk_cursor;
        end else if (is_push) begin
            ex_vld_d = 1'b1;
            ex_eng_d = eng;
            ex_op_d  = OP_PUSH;
            if (push_ok) begin
                ex_ptr_d = i_al_ptr;
                ex_dv_d  = lk.lk_dat_vld_w;
                ex_dat_d = lk.lk_dat_w;
            end else begin
                ex_err_d = ERR_FULL;
            end
        end else if (is_pop) begin
            ex_vld_d = 1'b1;
            ex_eng_d = eng;
            ex_op_d  = OP_POP;
            if (pop_ok) begin
                ex_ptr_d = cur_head;
            end else begin
                ex_err_d = ERR_EMPTY;
            end
        end else if (is_inv && !inv_walk) begin
            ex_vld_d = 1'b1;
            ex_eng_d = eng;
            ex_op_d  = OP_INV;
            ex_ptr_d = cur_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            lk.ex_vld_r     <= 1'b0;
            lk.ex_engid_r   <= '0;
            lk.ex_opcode_r  <= OP_PUSH;
            lk.ex_ptr_r     <= '0;
            lk.ex_dat_vld_r <= 1'b0;
            lk.ex_dat_r     <= '0;
            lk.ex_err_r     <= ERR_OK;
        end else begin
            lk.ex_vld_r     <= ex_vld_d;
            lk.ex_engid_r   <= ex_eng_d;
            lk.ex_opcode_r  <= ex_op_d;
            lk.ex_ptr_r     <= ex_ptr_d;
            lk.ex_dat_vld_r <= ex_dv_d;
            lk.ex_dat_r     <= ex_dat_d;
            lk.ex_err_r     <= ex_err_d;
        end
    end

    a_no_vld_while_busy: assert property (
        @(posedge clk) disable iff (!arst_n) walk_busy |-> !lk.lk_vld_w
    );

endmodule

// File: tb/tb_stk_pipe_lk.sv
// Directed bench for the LK stage: push/pop ordering, full/empty, INV walk and reset abort.
module tb_stk_pipe_lk;
    import stk_pkg::*;

    logic             clk;
    logic             arst_n;
    logic [PTR_W-1:0] i_al_ptr;
    logic             o_al_alloc;
    logic             o_fr_vld;
    logic [PTR_W-1:0] o_fr_ptr;
    logic             o_lk_busy;

    stk_pipe_lk_if bus ();

    stk_pipe_lk dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .lk         (bus),
        .i_al_ptr   (i_al_ptr),
        .o_al_alloc (o_al_alloc),
        .o_fr_vld   (o_fr_vld),
        .o_fr_ptr   (o_fr_ptr),
        .o_lk_busy  (o_lk_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic             al_s;
    logic             fr_s;
    logic [PTR_W-1:0] frp_s;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one microcode for a cycle, samples the combinational handshakes
    // mid-cycle, and returns just after the edge where EX outputs are registered.
    task automatic op(input engid_t e, input opcode_t o, input logic [PTR_W-1:0] p,
                      input logic dv, input logic [127:0] d);
        bus.lk_vld_w     = 1'b1;
        bus.lk_engid_w   = e;
        bus.lk_opcode_w  = o;
        bus.lk_dat_vld_w = dv;
        bus.lk_dat_w     = d;
        i_al_ptr         = p;
        #2;
        al_s  = o_al_alloc;
        fr_s  = o_fr_vld;
        frp_s = o_fr_ptr;
        @(posedge clk);
        #1;
        bus.lk_vld_w     = 1'b0;
        bus.lk_dat_vld_w = 1'b0;
    endtask

    task automatic chk_ex(input string tag, input opcode_t o, input engid_t e,
                          input logic [PTR_W-1:0] p, input err_t er);
        check({tag, ".vld"}, bus.ex_vld_r, 1'b1);
        check({tag, ".op"},  bus.ex_opcode_r, o);
        check({tag, ".eng"}, bus.ex_engid_r, e);
        check({tag, ".ptr"}, bus.ex_ptr_r, p);
        check({tag, ".err"}, bus.ex_err_r, er);
    endtask

    logic [PTR_W-1:0] fill_ptrs [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
    logic [PTR_W-1:0] pop0_exp  [8] = '{4'd10, 4'd8, 4'd6, 4'd4, 4'd2, 4'd1, 4'd0, 4'd3};
    logic [PTR_W-1:0] inv_exp   [3] = '{4'd11, 4'd4, 4'd9};

    initial begin
        arst_n           = 1'b0;
        bus.lk_vld_w     = 1'b0;
        bus.lk_engid_w   = '0;
        bus.lk_opcode_w  = OP_PUSH;
        bus.lk_dat_vld_w = 1'b0;
        bus.lk_dat_w     = '0;
        i_al_ptr         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ex_vld", bus.ex_vld_r, 1'b0);
        check("rst.ex_err", bus.ex_err_r, ERR_OK);
        check("rst.ex_ptr", bus.ex_ptr_r, 4'd0);
        check("rst.busy",   o_lk_busy, 1'b0);
        check("rst.fr_vld", o_fr_vld, 1'b0);
        arst_n = 1'b1;

        // First push on eng0
        op(2'd0, OP_PUSH, 4'd3, 1'b1, 128'hA5);
        check("p0.alloc", al_s, 1'b1);
        check("p0.fr",    fr_s, 1'b0);
        chk_ex("p0", OP_PUSH, 2'd0, 4'd3, ERR_OK);
        check("p0.dv",  bus.ex_dat_vld_r, 1'b1);
        check("p0.dat", bus.ex_dat_r, 128'hA5);
        @(posedge clk);
        #1;
        check("nop.ex_vld", bus.ex_vld_r, 1'b0);

        // eng1 LIFO order with back-to-back pops
        op(2'd1, OP_PUSH, 4'd5, 1'b1, 128'h55);
        op(2'd1, OP_PUSH, 4'd7, 1'b1, 128'h77);
        chk_ex("p1b", OP_PUSH, 2'd1, 4'd7, ERR_OK);
        op(2'd1, OP_POP, 4'd0, 1'b0, '0);
        check("q1a.fr",    fr_s, 1'b1);
        check("q1a.frptr", frp_s, 4'd7);
        check("q1a.alloc", al_s, 1'b0);
        chk_ex("q1a", OP_POP, 2'd1, 4'd7, ERR_OK);
        op(2'd1, OP_POP, 4'd0, 1'b0, '0);
        check("q1b.fr",    fr_s, 1'b1);
        check("q1b.frptr", frp_s, 4'd5);
        chk_ex("q1b", OP_POP, 2'd1, 4'd5, ERR_OK);
        op(2'd1, OP_POP, 4'd0, 1'b0, '0);
        check("q1c.fr", fr_s, 1'b0);
        chk_ex("q1c", OP_POP, 2'd1, 4'd0, ERR_EMPTY);

        // Empty engine
        op(2'd2, OP_POP, 4'd6, 1'b0, '0);
        check("q2.fr",    fr_s, 1'b0);
        check("q2.alloc", al_s, 1'b0);
        chk_ex("q2", OP_POP, 2'd2, 4'd0, ERR_EMPTY);

        // Fill eng0 to DEPTH_MAX then overflow
        for (int i = 0; i < 7; i++) begin
            op(2'd0, OP_PUSH, fill_ptrs[i], 1'b1, 128'(i));
            check($sformatf("fill%0d.alloc", i), al_s, 1'b1);
        end
        op(2'd0, OP_PUSH, 4'd12, 1'b1, 128'hFF);
        check("full.alloc", al_s, 1'b0);
        chk_ex("full", OP_PUSH, 2'd0, 4'd0, ERR_FULL);
        check("full.dv", bus.ex_dat_vld_r, 1'b0);
        for (int i = 0; i < 8; i++) begin
            op(2'd0, OP_POP, 4'd0, 1'b0, '0);
            check($sformatf("drain%0d.frptr", i), frp_s, pop0_exp[i]);
            check($sformatf("drain%0d.ptr", i), bus.ex_ptr_r, pop0_exp[i]);
        end
        op(2'd0, OP_POP, 4'd0, 1'b0, '0);
        chk_ex("drain8", OP_POP, 2'd0, 4'd0, ERR_EMPTY);

        // INV walk on eng3 holding {9,4,11}
        op(2'd3, OP_PUSH, 4'd9,  1'b1, 128'h9);
        op(2'd3, OP_PUSH, 4'd4,  1'b1, 128'h4);
        op(2'd3, OP_PUSH, 4'd11, 1'b1, 128'hB);
        op(2'd3, OP_INV, 4'd0, 1'b0, '0);
        check("inv.acc.fr", fr_s, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("walk%0d.busy", k),  o_lk_busy, 1'b1);
            check($sformatf("walk%0d.fr", k),    o_fr_vld, 1'b1);
            check($sformatf("walk%0d.frptr", k), o_fr_ptr, inv_exp[k]);
            check($sformatf("walk%0d.exvld", k), bus.ex_vld_r, 1'b0);
            @(posedge clk);
            #1;
        end
        #2;
        check("walkend.busy", o_lk_busy, 1'b0);
        check("walkend.fr",   o_fr_vld, 1'b0);
        chk_ex("inv", OP_INV, 2'd3, 4'd9, ERR_OK);
        op(2'd3, OP_PUSH, 4'd11, 1'b1, 128'h1);
        chk_ex("p3", OP_PUSH, 2'd3, 4'd11, ERR_OK);
        op(2'd3, OP_POP, 4'd0, 1'b0, '0);
        chk_ex("q3a", OP_POP, 2'd3, 4'd11, ERR_OK);
        op(2'd3, OP_POP, 4'd0, 1'b0, '0);
        chk_ex("q3b", OP_POP, 2'd3, 4'd0, ERR_EMPTY);

        // INV on an empty engine issues immediately
        op(2'd3, OP_INV, 4'd0, 1'b0, '0);
        check("inv0.fr", fr_s, 1'b0);
        chk_ex("inv0", OP_INV, 2'd3, 4'd0, ERR_OK);
        check("inv0.busy", o_lk_busy, 1'b0);

        // Reset in the middle of a walk
        op(2'd2, OP_PUSH, 4'd5, 1'b1, 128'h5);
        op(2'd1, OP_PUSH, 4'd2, 1'b1, 128'h2);
        op(2'd1, OP_PUSH, 4'd3, 1'b1, 128'h3);
        op(2'd1, OP_INV, 4'd0, 1'b0, '0);
        check("mid.busy", o_lk_busy, 1'b1);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        #2;
        check("abort.busy",  o_lk_busy, 1'b0);
        check("abort.exvld", bus.ex_vld_r, 1'b0);
        check("abort.fr",    o_fr_vld, 1'b0);
        for (int e = 0; e < 4; e++) begin
            op(engid_t'(e), OP_POP, 4'd0, 1'b0, '0);
            check($sformatf("post%0d.fr", e), fr_s, 1'b0);
            chk_ex($sformatf("post%0d", e), OP_POP, engid_t'(e), 4'd0, ERR_EMPTY);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
